// File: rtl/spm_seq_pkg.sv
// rtl/spm_seq_pkg.sv - shared state encoding and phase lengths for spm_seq
package spm_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } spm_seq_state_e;

    // Serial phase: N+M product bits, the first of which appears LAT cycles
    // after the first multiplier bit.
    function automatic int shift_len(input int n, input int m, input int lat);
        return n + m + lat;
    endfunction

    // Zero bits clocked through the array so every cell drains its stored
    // sum and carry before the next operand pair arrives.
    function automatic int flush_len(input int n);
        return n + 1;
    endfunction

endpackage

// File: rtl/spm_sipo.sv
// rtl/spm_sipo.sv - serial-in/parallel-out product collector
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-low reset, clears the collector
//   i_en    shift enable
//   i_bit   serial input bit
//   o_data  collected word; the first bit shifted in ends up at bit 0
//           after W shifts
module spm_sipo #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic         i_bit,
    output logic [W-1:0] o_data
);

    logic [W-1:0] r_data;

    // Bits enter at the MSB and walk down, so product bit 0 (captured
    // first) lands at bit 0 once all W bits have been taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
        end else if (i_en) begin
            r_data <= {i_bit, r_data[W-1:1]};
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/spm_seq.sv
// rtl/spm_seq.sv - operand sequencer and product collector for the spm array
//
// Ports:
//   clk, rst              clock; asynchronous active-low reset shared with spm
//   in_valid/in_ready     operand handshake; in_ready is high only in IDLE
//   in_x, in_y            signed multiplicand / multiplier
//   spm_x                 registered parallel multiplicand to spm
//   spm_y                 registered serial multiplier bit, LSB first
//   spm_p                 serial product bit from spm, LAT cycles behind spm_y
//   out_valid/out_ready   product handshake
//   out_p                 signed N+M bit product
module spm_seq
    import spm_seq_pkg::*;
#(
    parameter int N   = 32,
    parameter int M   = 32,
    parameter int LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_x,
    input  logic [M-1:0]   in_y,
    output logic [N-1:0]   spm_x,
    output logic           spm_y,
    input  logic           spm_p,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N+M-1:0] out_p
);

    localparam int CW        = $clog2(N + M + LAT + 1);
    localparam int SHIFT_LEN = shift_len(N, M, LAT);
    localparam int FLUSH_LEN = flush_len(N);

    localparam logic [CW-1:0] SHIFT_LAST = CW'(SHIFT_LEN - 1);
    localparam logic [CW-1:0] FLUSH_LAST = CW'(FLUSH_LEN - 1);
    localparam logic [CW-1:0] Y_LAST     = CW'(N + M - 1);
    localparam logic [CW-1:0] CAP_FIRST  = CW'(LAT);

    spm_seq_state_e r_state;
    spm_seq_state_e w_next_state;

    logic [CW-1:0] r_cnt;
    logic [M-1:0]  r_y_sr;
    logic [N-1:0]  r_spm_x;
    logic          r_spm_y;
    logic          r_out_valid;

    logic          w_accept;
    logic          w_capture;

    assign in_ready  = (r_state == IDLE);
    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_capture = (r_state == SHIFT) && (r_cnt >= CAP_FIRST);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:  if (w_accept)              w_next_state = SHIFT;
            SHIFT: if (r_cnt == SHIFT_LAST)   w_next_state = FLUSH;
            FLUSH: if (r_cnt == FLUSH_LAST)   w_next_state = DONE;
            DONE:  if (out_ready)             w_next_state = IDLE;
            default:                          w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Phase counter: restarts at 0 on every state change, so SHIFT and
    // FLUSH each see their own 0-based cycle index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_next_state != r_state) begin
            r_cnt <= '0;
        end else if (r_state == SHIFT || r_state == FLUSH) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Multiplier PISO. r_y_sr always holds the bits not yet presented;
    // the arithmetic shift replicates the sign so bits k >= M come out as
    // in_y[M-1].
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_y_sr  <= '0;
            r_spm_y <= 1'b0;
            r_spm_x <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_spm_x <= in_x;
                        r_spm_y <= in_y[0];
                        r_y_sr  <= {in_y[M-1], in_y[M-1:1]};
                    end
                end
                SHIFT: begin
                    if (r_cnt < Y_LAST) begin
                        r_spm_y <= r_y_sr[0];
                        r_y_sr  <= {r_y_sr[M-1], r_y_sr[M-1:1]};
                    end else begin
                        r_spm_y <= 1'b0;
                    end
                end
                default: r_spm_y <= 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
        end else if (r_state == FLUSH && r_cnt == FLUSH_LAST) begin
            r_out_valid <= 1'b1;
        end else if (r_state == DONE && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    spm_sipo #(
        .W (N + M)
    ) u_sipo (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_capture),
        .i_bit  (spm_p),
        .o_data (out_p)
    );

    assign spm_x     = r_spm_x;
    assign spm_y     = r_spm_y;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_spm_seq.sv
// tb/tb_spm_seq.sv - self-checking bench for spm_seq with behavioural spm arrays
module tb_spm_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- 8x8 instance ----------------
    logic        in_valid8 = 1'b0, in_ready8, spm_y8, spm_p8, out_valid8, out_ready8 = 1'b0;
    logic [7:0]  in_x8 = '0, in_y8 = '0, spm_x8;
    logic [15:0] out_p8;

    spm_seq #(.N(8), .M(8), .LAT(1)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_x(in_x8), .in_y(in_y8),
        .spm_x(spm_x8), .spm_y(spm_y8), .spm_p(spm_p8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_p(out_p8)
    );

    // ---------------- 32x32 instance ----------------
    logic        in_valid32 = 1'b0, in_ready32, spm_y32, spm_p32, out_valid32, out_ready32 = 1'b0;
    logic [31:0] in_x32 = '0, in_y32 = '0, spm_x32;
    logic [63:0] out_p32;

    spm_seq #(.N(32), .M(32), .LAT(1)) u_dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid32), .in_ready(in_ready32), .in_x(in_x32), .in_y(in_y32),
        .spm_x(spm_x32), .spm_y(spm_y32), .spm_p(spm_p32),
        .out_valid(out_valid32), .out_ready(out_ready32), .out_p(out_p32)
    );

    // Behavioural serial-parallel multiplier, one cycle latency: each cycle
    // adds x*ybit to a running signed accumulator and emits its LSB.
    longint acc8, acc32, sum8, sum32;
    assign sum8  = acc8  + (spm_y8  ? longint'($signed(spm_x8))  : 64'sd0);
    assign sum32 = acc32 + (spm_y32 ? longint'($signed(spm_x32)) : 64'sd0);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc8 <= 0; spm_p8 <= 1'b0;
        end else if (in_valid8 && in_ready8) begin
            acc8 <= 0; spm_p8 <= 1'b0;
        end else begin
            acc8 <= sum8 >>> 1; spm_p8 <= sum8[0];
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc32 <= 0; spm_p32 <= 1'b0;
        end else if (in_valid32 && in_ready32) begin
            acc32 <= 0; spm_p32 <= 1'b0;
        end else begin
            acc32 <= sum32 >>> 1; spm_p32 <= sum32[0];
        end
    end

    function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y);
        int p;
        p = int'($signed(x)) * int'($signed(y));
        return p[15:0];
    endfunction

    function automatic logic [63:0] ref32(input logic [31:0] x, input logic [31:0] y);
        return longint'($signed(x)) * longint'($signed(y));
    endfunction

    // Runs one 8-bit operation; lat is the cycle index (cycle right after the
    // acceptance edge = 1) in which out_valid is first seen.
    task automatic run8(input logic [7:0] x, input logic [7:0] y,
                        output logic [15:0] p, output int lat, output bit ok);
        int n;
        ok = 1'b1; p = '0; lat = 0;
        in_x8 = x; in_y8 = y; in_valid8 = 1'b1;
        n = 0;
        while (!in_ready8 && n < 200) begin @(posedge clk); #1; n++; end
        if (!in_ready8) begin ok = 1'b0; in_valid8 = 1'b0; return; end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 1;
        while (!out_valid8 && lat < 200) begin @(posedge clk); #1; lat++; end
        if (!out_valid8) begin ok = 1'b0; return; end
        p = out_p8;
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready8); end
        checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid8); end
        checks++; if (out_p8 !== 16'h0) begin errors++; $display("FAIL reset_out_p got %h want 0000", out_p8); end
        checks++; if (spm_x8 !== 8'h0 || spm_y8 !== 1'b0) begin errors++; $display("FAIL reset_spm got x=%h y=%b want 00/0", spm_x8, spm_y8); end
        checks++; if (in_ready32 !== 1'b1 || out_valid32 !== 1'b0 || out_p32 !== 64'h0) begin
            errors++; $display("FAIL reset_dut32 got rdy=%b vld=%b p=%h want 1/0/0", in_ready32, out_valid32, out_p32); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [7:0]  xs [5] = '{8'd3, 8'hFD, 8'h80, 8'h7F, 8'hFF};
        logic [7:0]  ys [5] = '{8'd5, 8'd5,  8'h80, 8'h81, 8'h00};
        logic [15:0] p;
        int lat; bit ok;
        for (int i = 0; i < 5; i++) begin
            run8(xs[i], ys[i], p, lat, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL directed_timeout op %0d", i); end
            else if (p !== ref8(xs[i], ys[i])) begin
                errors++; $display("FAIL directed_prod x=%h y=%h got %h want %h", xs[i], ys[i], p, ref8(xs[i], ys[i])); end
            if (i == 0) begin
                checks++;
                if (lat !== 2*8 + 8 + 1 + 2) begin errors++; $display("FAIL latency got %0d want %0d", lat, 2*8+8+1+2); end
            end
        end
        for (int i = 0; i < 40; i++) begin
            logic [7:0] x, y;
            x = 8'($urandom); y = 8'($urandom);
            run8(x, y, p, lat, ok);
            checks++;
            if (!ok || p !== ref8(x, y)) begin
                errors++; $display("FAIL rand8_prod x=%h y=%h got %h want %h ok=%0d", x, y, p, ref8(x, y), ok); end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] held, p;
        int n, lat; bit ok;
        bit stable_ok;
        in_x8 = 8'd11; in_y8 = 8'hF3; in_valid8 = 1'b1;
        n = 0;
        while (!in_ready8 && n < 200) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 200) begin @(posedge clk); #1; n++; end
        checks++;
        if (!out_valid8) begin errors++; $display("FAIL bp_timeout no out_valid"); return; end
        held = out_p8;
        checks++;
        if (held !== ref8(8'd11, 8'hF3)) begin errors++; $display("FAIL bp_prod got %h want %h", held, ref8(8'd11, 8'hF3)); end
        in_x8 = 8'h22; in_y8 = 8'h05; in_valid8 = 1'b1;
        stable_ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (out_p8 !== held || in_ready8 !== 1'b0 || out_valid8 !== 1'b1) begin
                stable_ok = 1'b0;
                $display("FAIL bp_hold cycle %0d got p=%h rdy=%b vld=%b want %h/0/1", c, out_p8, in_ready8, out_valid8, held);
            end
        end
        checks++; if (!stable_ok) errors++;
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || spm_x8 !== 8'd11) begin
            errors++; $display("FAIL bp_consume got rdy=%b vld=%b spm_x=%h want 1/0/0b", in_ready8, out_valid8, spm_x8); end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        checks++;
        if (spm_x8 !== 8'h22 || in_ready8 !== 1'b0) begin
            errors++; $display("FAIL bp_accept got spm_x=%h rdy=%b want 22/0", spm_x8, in_ready8); end
        n = 0;
        while (!out_valid8 && n < 200) begin @(posedge clk); #1; n++; end
        p = out_p8;
        out_ready8 = 1'b1; @(posedge clk); #1; out_ready8 = 1'b0;
        checks++;
        if (p !== ref8(8'h22, 8'h05)) begin errors++; $display("FAIL bp_second got %h want %h", p, ref8(8'h22, 8'h05)); end
        lat = 0; ok = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [15:0] res [2];
        int got, accepted;
        bit pending;
        got = 0; accepted = 0; pending = 1'b0;
        in_x8 = 8'd3; in_y8 = 8'd5; in_valid8 = 1'b1; out_ready8 = 1'b1;
        for (int c = 0; c < 200 && got < 2; c++) begin
            if (pending) begin
                accepted++;
                if (accepted == 1) begin in_x8 = 8'hFF; in_y8 = 8'hFF; end
                else in_valid8 = 1'b0;
            end
            pending = in_valid8 && in_ready8;
            if (out_valid8) begin res[got] = out_p8; got++; end
            @(posedge clk); #1;
        end
        in_valid8 = 1'b0; out_ready8 = 1'b0;
        checks++;
        if (got != 2) begin errors++; $display("FAIL b2b_count got %0d want 2", got); end
        else begin
            checks++;
            if (res[0] !== ref8(8'd3, 8'd5)) begin errors++; $display("FAIL b2b_first got %h want %h", res[0], ref8(8'd3, 8'd5)); end
            checks++;
            if (res[1] !== ref8(8'hFF, 8'hFF)) begin errors++; $display("FAIL b2b_second got %h want %h", res[1], ref8(8'hFF, 8'hFF)); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [15:0] p;
        int n, lat; bit ok;
        in_x8 = 8'h5A; in_y8 = 8'hC3; in_valid8 = 1'b1;
        n = 0;
        while (!in_ready8 && n < 200) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid8 !== 1'b0 || spm_x8 !== 8'h0 || out_p8 !== 16'h0 || spm_y8 !== 1'b0) begin
            errors++; $display("FAIL rst_async got vld=%b x=%h p=%h y=%b want 0/00/0000/0", out_valid8, spm_x8, out_p8, spm_y8); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
            errors++; $display("FAIL rst_recover got rdy=%b vld=%b want 1/0", in_ready8, out_valid8); end
        run8(8'd7, 8'd9, p, lat, ok);
        checks++;
        if (!ok || p !== ref8(8'd7, 8'd9)) begin errors++; $display("FAIL rst_after_op got %h want %h ok=%0d", p, ref8(8'd7, 8'd9), ok); end
    endtask

    task automatic test_random32();
        logic [31:0] corners [5] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1};
        logic [31:0] x, y;
        logic [63:0] p;
        int n, bad;
        bad = 0;
        for (int op = 0; op < 250; op++) begin
            x = $urandom; y = $urandom;
            if ($urandom_range(0, 5) == 0) x = corners[$urandom_range(0, 4)];
            if ($urandom_range(0, 5) == 0) y = corners[$urandom_range(0, 4)];
            if (op == 0) begin x = 32'h8000_0000; y = 32'h8000_0000; end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            in_x32 = x; in_y32 = y; in_valid32 = 1'b1;
            n = 0;
            while (!in_ready32 && n < 300) begin @(posedge clk); #1; n++; end
            @(posedge clk); #1;
            in_valid32 = 1'b0;
            in_x32 = $urandom; in_y32 = $urandom;
            n = 0;
            while (!out_valid32 && n < 300) begin @(posedge clk); #1; n++; end
            checks++;
            if (!out_valid32) begin errors++; $display("FAIL rand32_timeout op %0d", op); return; end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            p = out_p32;
            out_ready32 = 1'b1;
            @(posedge clk); #1;
            out_ready32 = 1'b0;
            if (p !== ref32(x, y)) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rand32_prod x=%h y=%h got %h want %h", x, y, p, ref32(x, y));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random32();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
